// File: rtl/pipe_hazard_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl_pkg
// Shared defaults and helpers for the decode/execute hazard control path.
//   - Default register-address width, latencies and flush depth.
//   - Opcode-class constants decode uses to derive id_is_load.
//   - clog2 helper clamped to a minimum width of one bit, so a counter whose
//     largest value is 0 still gets a legal vector.
// -----------------------------------------------------------------------------
package pipe_hazard_ctrl_pkg;

    localparam int DEF_REG_AW      = 5;
    localparam int DEF_ALU_LAT     = 0;
    localparam int DEF_LOAD_LAT    = 1;
    localparam int DEF_FLUSH_DEPTH = 2;

    // Major opcode classes (RV32-style encoding); decode flags a load when the
    // opcode class equals OPC_LOAD.
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

    // Number of bits needed to hold values 0..value-1, never less than 1.
    function automatic int clog2_min1(input int value);
        int w;
        w = $clog2(value);
        return (w < 1) ? 1 : w;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic is_load_opc(input logic [6:0] opc);
        return (opc == OPC_LOAD);
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_scoreboard.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard
// Per-register latency scoreboard. Each register r >= 1 owns a down-counter
// that is loaded with the producer's latency when an instruction writing r
// issues, and counts down by one every cycle. Register 0 has no counter.
//
// Ports:
//   clk, rst          core clock, synchronous active-low reset
//   rd_addr_a/busy_a  combinational lookup: counter of rd_addr_a is nonzero
//   rd_addr_b/busy_b  second combinational lookup port
//   set_vld           load the counter of set_addr this cycle
//   set_addr          register being written by the issuing instruction
//   set_is_load       issuing instruction is a load (selects LOAD_LAT)
//   busy_mask         registered; bit r set while counter r is nonzero
// -----------------------------------------------------------------------------
module hazard_scoreboard
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int REG_AW   = DEF_REG_AW,
    parameter int ALU_LAT  = DEF_ALU_LAT,
    parameter int LOAD_LAT = DEF_LOAD_LAT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [REG_AW-1:0]        rd_addr_a,
    output logic                     busy_a,
    input  logic [REG_AW-1:0]        rd_addr_b,
    output logic                     busy_b,
    input  logic                     set_vld,
    input  logic [REG_AW-1:0]        set_addr,
    input  logic                     set_is_load,
    output logic [(1<<REG_AW)-1:0]   busy_mask
);

    localparam int NREG = 1 << REG_AW;
    localparam int CW   = clog2_min1(max_int(ALU_LAT, LOAD_LAT) + 1);

    localparam logic [CW-1:0] ALU_VAL  = CW'(ALU_LAT);
    localparam logic [CW-1:0] LOAD_VAL = CW'(LOAD_LAT);

    logic [NREG-1:0] busy_next;
    logic [NREG-1:0] busy_mask_reg;

    // x0 is hard-wired zero and can never be pending.
    assign busy_next[0] = 1'b0;

    generate
        for (genvar gi = 1; gi < NREG; gi++) begin : gen_reg
            logic [CW-1:0] cnt_reg;
            logic [CW-1:0] cnt_next;

            // Loading a new latency overrides this cycle's decrement.
            always_comb begin
                cnt_next = cnt_reg;
                if (cnt_reg != '0) begin
                    cnt_next = cnt_reg - CW'(1);
                end
                if (set_vld && (set_addr == REG_AW'(gi))) begin
                    cnt_next = set_is_load ? LOAD_VAL : ALU_VAL;
                end
            end

            always_ff @(posedge clk) begin
                if (!rst) begin
                    cnt_reg <= '0;
                end else begin
                    cnt_reg <= cnt_next;
                end
            end

            assign busy_next[gi] = (cnt_next != '0);
        end
    endgenerate

    // busy_mask_reg tracks (cnt_reg != 0) exactly, so the lookups read it
    // instead of re-reducing every counter.
    always_ff @(posedge clk) begin
        if (!rst) begin
            busy_mask_reg <= '0;
        end else begin
            busy_mask_reg <= busy_next;
        end
    end

    assign busy_a    = busy_mask_reg[rd_addr_a];
    assign busy_b    = busy_mask_reg[rd_addr_b];
    assign busy_mask = busy_mask_reg;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
// Decode/execute hazard and jump-flush control. A per-register latency
// scoreboard stalls consumers of results that cannot yet be forwarded, and a
// taken EX jump opens a FLUSH_DEPTH-slot kill window on the decode slot.
//
// Ports:
//   clk, rst               core clock, synchronous active-low reset
//   id_vld                 decode slot holds an instruction
//   id_rs1/_vld, id_rs2/_vld  source addresses and read enables
//   id_rd/_vld             destination address and write enable
//   id_is_load             instruction is a load
//   ex_jmp_vld             taken jump/branch resolved in EX this cycle
//   hold_if                comb; freeze fetch and the decode register
//   kill_id                comb; decode slot is squashed
//   ex_inst_vld            registered; EX holds a valid issued instruction
//   busy_mask              registered; per-register pending-result flags
//   stall_cycles           (HAZARD_STATS_EN) saturating count of hold_if cycles
//   flush_events           (HAZARD_STATS_EN) saturating count of ex_jmp_vld cycles
//
// Build option: define HAZARD_STATS_EN to add the two statistics outputs.
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int REG_AW      = DEF_REG_AW,
    parameter int ALU_LAT     = DEF_ALU_LAT,
    parameter int LOAD_LAT    = DEF_LOAD_LAT,
    parameter int FLUSH_DEPTH = DEF_FLUSH_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     id_vld,
    input  logic [REG_AW-1:0]        id_rs1,
    input  logic                     id_rs1_vld,
    input  logic [REG_AW-1:0]        id_rs2,
    input  logic                     id_rs2_vld,
    input  logic [REG_AW-1:0]        id_rd,
    input  logic                     id_rd_vld,
    input  logic                     id_is_load,
    input  logic                     ex_jmp_vld,
    output logic                     hold_if,
    output logic                     kill_id,
    output logic                     ex_inst_vld,
    output logic [(1<<REG_AW)-1:0]   busy_mask
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0]              stall_cycles,
    output logic [15:0]              flush_events
`endif
);

    localparam int KW = clog2_min1(FLUSH_DEPTH);
    localparam logic [KW-1:0] KILL_RELOAD = KW'(FLUSH_DEPTH - 1);

    logic          rs1_busy;
    logic          rs2_busy;
    logic          haz;
    logic          fire;
    logic          set_vld;
    logic [KW-1:0] kill_cnt_reg;
    logic [KW-1:0] kill_cnt_next;
    logic          ex_inst_vld_reg;

    hazard_scoreboard #(
        .REG_AW   (REG_AW),
        .ALU_LAT  (ALU_LAT),
        .LOAD_LAT (LOAD_LAT)
    ) u_scoreboard (
        .clk         (clk),
        .rst         (rst),
        .rd_addr_a   (id_rs1),
        .busy_a      (rs1_busy),
        .rd_addr_b   (id_rs2),
        .busy_b      (rs2_busy),
        .set_vld     (set_vld),
        .set_addr    (id_rd),
        .set_is_load (id_is_load),
        .busy_mask   (busy_mask)
    );

    // The jump itself squashes the slot in its own cycle; the counter covers
    // the remaining FLUSH_DEPTH-1 slots.
    assign kill_id = (kill_cnt_reg != '0) | ex_jmp_vld;

    // A killed slot never stalls, so a flush always releases fetch.
    assign haz = id_vld & ~kill_id &
                 ((id_rs1_vld & (id_rs1 != '0) & rs1_busy) |
                  (id_rs2_vld & (id_rs2 != '0) & rs2_busy));

    assign hold_if = haz & ~ex_jmp_vld;
    assign fire    = id_vld & ~kill_id & ~haz & ~ex_jmp_vld;
    assign set_vld = fire & id_rd_vld & (id_rd != '0);

    // A jump inside an open window reloads it rather than extending it.
    always_comb begin
        kill_cnt_next = kill_cnt_reg;
        if (ex_jmp_vld) begin
            kill_cnt_next = KILL_RELOAD;
        end else if (kill_cnt_reg != '0) begin
            kill_cnt_next = kill_cnt_reg - KW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            kill_cnt_reg    <= '0;
            ex_inst_vld_reg <= 1'b0;
        end else begin
            kill_cnt_reg    <= kill_cnt_next;
            ex_inst_vld_reg <= fire;
        end
    end

    assign ex_inst_vld = ex_inst_vld_reg;

`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cycles_reg;
    logic [15:0] flush_events_reg;

    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cycles_reg <= '0;
            flush_events_reg <= '0;
        end else begin
            if (hold_if && (stall_cycles_reg != 32'hFFFF_FFFF)) begin
                stall_cycles_reg <= stall_cycles_reg + 32'd1;
            end
            if (ex_jmp_vld && (flush_events_reg != 16'hFFFF)) begin
                flush_events_reg <= flush_events_reg + 16'd1;
            end
        end
    end

    assign stall_cycles = stall_cycles_reg;
    assign flush_events = flush_events_reg;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
// Two instances share one stimulus stream: instance 0 uses the default
// parameters (ALU 0, LOAD 1, FLUSH 2), instance 1 uses ALU 1, LOAD 3, FLUSH 3.
// The reference model tracks, per register, the absolute cycle at which its
// result becomes forwardable, and the cycle at which the kill window closes.
// -----------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

    localparam int NI = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_vld;
    logic [4:0]  id_rs1;
    logic        id_rs1_vld;
    logic [4:0]  id_rs2;
    logic        id_rs2_vld;
    logic [4:0]  id_rd;
    logic        id_rd_vld;
    logic        id_is_load;
    logic        ex_jmp_vld;

    logic [NI-1:0] hold_w;
    logic [NI-1:0] kill_w;
    logic [NI-1:0] exv_w;
    logic [31:0]   busy_w  [NI];
    logic [31:0]   stall_w [NI];
    logic [15:0]   flush_w [NI];

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(
        .REG_AW(5), .ALU_LAT(0), .LOAD_LAT(1), .FLUSH_DEPTH(2)
    ) dut_a (
        .clk(clk), .rst(rst), .id_vld(id_vld),
        .id_rs1(id_rs1), .id_rs1_vld(id_rs1_vld),
        .id_rs2(id_rs2), .id_rs2_vld(id_rs2_vld),
        .id_rd(id_rd), .id_rd_vld(id_rd_vld), .id_is_load(id_is_load),
        .ex_jmp_vld(ex_jmp_vld),
        .hold_if(hold_w[0]), .kill_id(kill_w[0]),
        .ex_inst_vld(exv_w[0]), .busy_mask(busy_w[0])
`ifdef HAZARD_STATS_EN
        , .stall_cycles(stall_w[0]), .flush_events(flush_w[0])
`endif
    );

    pipe_hazard_ctrl #(
        .REG_AW(5), .ALU_LAT(1), .LOAD_LAT(3), .FLUSH_DEPTH(3)
    ) dut_b (
        .clk(clk), .rst(rst), .id_vld(id_vld),
        .id_rs1(id_rs1), .id_rs1_vld(id_rs1_vld),
        .id_rs2(id_rs2), .id_rs2_vld(id_rs2_vld),
        .id_rd(id_rd), .id_rd_vld(id_rd_vld), .id_is_load(id_is_load),
        .ex_jmp_vld(ex_jmp_vld),
        .hold_if(hold_w[1]), .kill_id(kill_w[1]),
        .ex_inst_vld(exv_w[1]), .busy_mask(busy_w[1])
`ifdef HAZARD_STATS_EN
        , .stall_cycles(stall_w[1]), .flush_events(flush_w[1])
`endif
    );

`ifndef HAZARD_STATS_EN
    initial begin
        stall_w[0] = '0; stall_w[1] = '0;
        flush_w[0] = '0; flush_w[1] = '0;
    end
`endif

    // ---------------- reference model ----------------
    int alu_lat [NI] = '{0, 1};
    int load_lat[NI] = '{1, 3};
    int flush_d [NI] = '{2, 3};

    int          ready_at [NI][32];
    int          kill_end [NI];
    bit          ex_vld_m [NI];
    longint      stall_m  [NI];
    longint      flush_m  [NI];
    int          cyc = 0;

    typedef struct packed {
        bit   [1:0]  hold;
        bit   [1:0]  kill;
        bit   [1:0]  exv;
        logic [63:0] busy;
        logic [63:0] stall;
        logic [31:0] flush;
    } exp_t;

    exp_t exp_q[$];

    int n_tests = 0;
    int n_fail  = 0;
    int mon_cyc = 0;

    task automatic check(input string name, input int k,
                         input logic [63:0] got, input logic [63:0] expv);
        n_tests++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s inst=%0d cycle=%0d got=%h expected=%h",
                     name, k, mon_cyc, got, expv);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NI; k++) begin
            for (int r = 0; r < 32; r++) ready_at[k][r] = 0;
            kill_end[k] = 0;
            ex_vld_m[k] = 1'b0;
            stall_m[k]  = 0;
            flush_m[k]  = 0;
        end
    endtask

    // Expected outputs for the current cycle, then advance the model.
    task automatic predict();
        exp_t e;
        e = '0;
        for (int k = 0; k < NI; k++) begin
            logic [31:0] bm;
            bit kl, hz, hd, fr;
            bm = '0;
            for (int r = 1; r < 32; r++) begin
                if (cyc < ready_at[k][r]) bm[r] = 1'b1;
            end
            kl = (cyc < kill_end[k]) || ex_jmp_vld;
            hz = id_vld && !kl && ((id_rs1_vld && bm[id_rs1]) ||
                                   (id_rs2_vld && bm[id_rs2]));
            hd = hz && !ex_jmp_vld;
            fr = id_vld && !kl && !hz && !ex_jmp_vld;

            e.hold[k]           = hd;
            e.kill[k]           = kl;
            e.exv[k]            = ex_vld_m[k];
            e.busy[k*32 +: 32]  = bm;
            e.stall[k*32 +: 32] = 32'(stall_m[k]);
            e.flush[k*16 +: 16] = 16'(flush_m[k]);

            if (!rst) begin
                for (int r = 0; r < 32; r++) ready_at[k][r] = 0;
                kill_end[k] = 0;
                ex_vld_m[k] = 1'b0;
                stall_m[k]  = 0;
                flush_m[k]  = 0;
            end else begin
                if (fr && id_rd_vld && id_rd != 0)
                    ready_at[k][id_rd] = cyc + 1 + (id_is_load ? load_lat[k] : alu_lat[k]);
                if (ex_jmp_vld) kill_end[k] = cyc + flush_d[k];
                ex_vld_m[k] = fr;
                if (hd && stall_m[k] < 64'hFFFF_FFFF) stall_m[k]++;
                if (ex_jmp_vld && flush_m[k] < 64'hFFFF) flush_m[k]++;
            end
        end
        exp_q.push_back(e);
        cyc++;
    endtask

    task automatic step(input bit vld, input int rs1, input bit rs1v,
                        input int rs2, input bit rs2v, input int rd,
                        input bit rdv, input bit ld, input bit jmp,
                        input bit rstn);
        @(posedge clk);
        #1;
        rst        = rstn;
        id_vld     = vld;
        id_rs1     = 5'(rs1);
        id_rs1_vld = rs1v;
        id_rs2     = 5'(rs2);
        id_rs2_vld = rs2v;
        id_rd      = 5'(rd);
        id_rd_vld  = rdv;
        id_is_load = ld;
        ex_jmp_vld = jmp;
        predict();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            for (int k = 0; k < NI; k++) begin
                check("hold_if",     k, 64'(hold_w[k]), 64'(e.hold[k]));
                check("kill_id",     k, 64'(kill_w[k]), 64'(e.kill[k]));
                check("ex_inst_vld", k, 64'(exv_w[k]),  64'(e.exv[k]));
                check("busy_mask",   k, 64'(busy_w[k]), 64'(e.busy[k*32 +: 32]));
`ifdef HAZARD_STATS_EN
                check("stall_cycles", k, 64'(stall_w[k]), 64'(e.stall[k*32 +: 32]));
                check("flush_events", k, 64'(flush_w[k]), 64'(e.flush[k*16 +: 16]));
`endif
            end
            $display("[TB] cyc=%0d rst=%b vld=%b jmp=%b hold=%b kill=%b exv=%b busy0=%h busy1=%h",
                     mon_cyc, rst, id_vld, ex_jmp_vld, hold_w, kill_w, exv_w,
                     busy_w[0], busy_w[1]);
            mon_cyc++;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b0; id_vld = 0; id_rs1 = 0; id_rs1_vld = 0; id_rs2 = 0;
        id_rs2_vld = 0; id_rd = 0; id_rd_vld = 0; id_is_load = 0; ex_jmp_vld = 0;
        model_reset();
        repeat (3) @(posedge clk);

        // reset state observed while still in reset
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // load x5 then add x6,x5,x1 (consumer held, then replayed)
        step(1, 1, 1, 2, 1, 5, 1, 1, 0, 1);
        step(1, 5, 1, 1, 1, 6, 1, 0, 0, 1);
        step(1, 5, 1, 1, 1, 6, 1, 0, 0, 1);
        idle(4);
        // add x5 then sub x7,x5,x5
        step(1, 1, 1, 2, 1, 5, 1, 0, 0, 1);
        step(1, 5, 1, 5, 1, 7, 1, 0, 0, 1);
        idle(3);
        // load writing x0, then consumer of x0
        step(1, 1, 1, 0, 0, 0, 1, 1, 0, 1);
        step(1, 0, 1, 0, 1, 8, 1, 0, 0, 1);
        idle(3);
        // load-use stall interrupted by a jump
        step(1, 1, 1, 0, 0, 5, 1, 1, 0, 1);
        step(1, 5, 1, 0, 0, 6, 1, 0, 1, 1);
        step(1, 5, 1, 0, 0, 6, 1, 0, 0, 1);
        step(1, 5, 1, 0, 0, 6, 1, 0, 0, 1);
        idle(4);
        // back-to-back jumps reload the window
        step(1, 1, 1, 0, 0, 3, 1, 0, 1, 1);
        step(1, 1, 1, 0, 0, 3, 1, 0, 1, 1);
        step(1, 1, 1, 0, 0, 3, 1, 0, 0, 1);
        step(1, 1, 1, 0, 0, 3, 1, 0, 0, 1);
        step(1, 1, 1, 0, 0, 3, 1, 0, 0, 1);
        idle(3);
        // reset while x9's load counter is mid-count
        step(1, 1, 1, 0, 0, 9, 1, 1, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        step(1, 9, 1, 0, 0, 4, 1, 0, 0, 0);
        step(1, 9, 1, 0, 0, 4, 1, 0, 0, 1);
        idle(2);

        // randomized traffic on a small register window
        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(0, 9) < 8,
                 $urandom_range(0, 7), $urandom_range(0, 3) != 0,
                 $urandom_range(0, 7), $urandom_range(0, 3) != 0,
                 $urandom_range(0, 7), $urandom_range(0, 4) != 0,
                 $urandom_range(0, 2) == 0,
                 $urandom_range(0, 11) == 0,
                 $urandom_range(0, 63) != 0);
        end
        idle(2);

        repeat (3) @(negedge clk);
        check("queue_drain", 0, 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Parametrised successor to the core's fixed hazard/jump control path. It holds a per-register latency scoreboard that replaces the single-stage load-use check, so load latency and ALU latency are configurable. It also generates a configurable multi-cycle flush/kill window on a taken EX jump. The block sits between decode and execute: it drives fetch hold, the EX instruction-valid strobe and the decode-kill signal.

Parameters:
REG_AW, 5, register address width; number of registers NREG = 2**REG_AW; register 0 is hard-wired zero.
ALU_LAT, 0, cycles after issue before an ALU result can be forwarded (0 = EX forwarding, never stalls).
LOAD_LAT, 1, cycles after issue before a load result can be forwarded.
FLUSH_DEPTH, 2, pipeline slots killed by a taken jump, counting the decode slot in the jump cycle; minimum 1.

Ports:
clk  in  1  core clock.
rst  in  1  synchronous reset, active-low (asserted when 0).
id_vld  in  1  decode slot holds an instruction.
id_rs1  in  REG_AW  source 1 address.
id_rs1_vld  in  1  source 1 is read.
id_rs2  in  REG_AW  source 2 address.
id_rs2_vld  in  1  source 2 is read.
id_rd  in  REG_AW  destination address.
id_rd_vld  in  1  destination is written.
id_is_load  in  1  instruction is a load.
ex_jmp_vld  in  1  taken jump/branch resolved in EX this cycle.
hold_if  out  1  combinational; freeze fetch and decode register.
kill_id  out  1  combinational; decode slot is squashed.
ex_inst_vld  out  1  registered; the EX stage holds a valid issued instruction.
busy_mask  out  NREG  registered; bit r set while the scoreboard counter for r is nonzero.

Behaviour:
- Reset (rst==0 at a clk edge): all scoreboard counters = 0, kill counter = 0, ex_inst_vld = 0, busy_mask = 0. Reset applied mid-stall or mid-flush aborts the stall or flush with no residue.
- Scoreboard: one counter per register, width clog2(max(ALU_LAT,LOAD_LAT)+1). Register 0 is never set. Each cycle every nonzero counter decrements by 1.
- Hazard: haz = id_vld & ~kill_id & ((id_rs1_vld & id_rs1!=0 & cnt[id_rs1]!=0) | same for rs2). The check uses the counter value at the start of the cycle.
- Issue fire = id_vld & ~kill_id & ~haz & ~ex_jmp_vld.
- On fire with id_rd_vld and id_rd!=0: cnt[id_rd] <= id_is_load ? LOAD_LAT : ALU_LAT. If this coincides with the decrement of the same register, the load of the new value wins.
- ex_inst_vld <= fire. A stall inserts exactly one bubble per stalled cycle.
- hold_if = haz & ~ex_jmp_vld. A flush overrides a stall so fetch can redirect.
- Flush:
  - ex_jmp_vld in cycle t squashes the decode slot at t, so ex_inst_vld at t+1 = 0.
  - kill counter <= FLUSH_DEPTH-1.
  - kill_id = (kill counter != 0) | ex_jmp_vld. While kill_id is set there is no issue and no stall.
  - The kill counter decrements to 0.
  - ex_jmp_vld arriving during an active window reloads the window.
  - Scoreboard entries already issued keep counting, because they are older and committed.
- Latency: hazard detection and hold_if are same-cycle combinational. Scoreboard and ex_inst_vld update one cycle after fire.

Optional Feature:
HAZARD_STATS_EN
- Defined:
  - Adds output stall_cycles (32 bit), which counts cycles with hold_if=1.
  - Adds output flush_events (16 bit), which counts ex_jmp_vld pulses.
  - Both counters saturate at all-ones and clear on reset.
- Undefined: both ports and both counters are absent. Behaviour is otherwise identical.

Decomposition:
- Shared package/defines: REG_AW default, latency defaults, a clog2 macro, and the opcode-class constants used to derive id_is_load.
- One natural sub-module, hazard_scoreboard: owns the counter array, decrement/load logic and busy_mask, and exposes two combinational lookup ports.

Test Plan:
- Load x5 (LOAD_LAT=1), then add x6,x5,x1 in the next slot -> hold_if=1 for 1 cycle, ex_inst_vld pattern 1,0,1, busy_mask[5] set for 1 cycle.
- ALU_LAT=0: add x5 followed by sub x7,x5,x5 -> no hold, ex_inst_vld 1,1, busy_mask stays 0.
- Load writing x0, then a consumer reading x0 -> no stall, busy_mask[0] never set.
- ex_jmp_vld pulse while a load-use stall is active, FLUSH_DEPTH=2 -> hold_if=0 that cycle, kill_id=1 for 2 cycles, ex_inst_vld=0 for 2 cycles.
- Second ex_jmp_vld one cycle into a kill window -> window reloads, kill_id=1 for 3 consecutive cycles total.
- rst=0 with LOAD_LAT=3 while the counter for x9 = 2 -> busy_mask=0 and ex_inst_vld=0 the next cycle; with HAZARD_STATS_EN, stall_cycles=0 after reset.
